// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell and a borrow flop compute A - B - Bin, LSB first.
// Results are registered on leaving DONE, alongside a one-cycle Done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic             accept;
    logic             last;
    logic             bit_d;
    logic             brw_nxt;

    // DONE is not busy, so a Start seen there starts the next operation back-to-back.
    assign accept  = Start && (state != S_SHIFT);
    assign last    = (cnt == CW'(WIDTH - 1));
    assign Busy    = (state == S_SHIFT);
    assign bit_d   = a_sh[0] ^ b_sh[0] ^ brw;
    assign brw_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_SHIFT;
            S_SHIFT: if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = accept ? S_SHIFT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs capture the finished result while the datapath may already load the next operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
            Ovf   <= 1'b0;
            Done  <= 1'b0;
        end else begin
            if (state == S_DONE) begin
                Diff <= res;
                Bout <= brw;
                Ovf  <= (a_msb != b_msb) && (res[WIDTH-1] != a_msb);
                Done <= 1'b1;
            end else begin
                Done <= 1'b0;
            end

            if (accept) begin
                a_sh  <= A;
                b_sh  <= B;
                brw   <= Bin;
                cnt   <= '0;
                a_msb <= A[WIDTH-1];
                b_msb <= B[WIDTH-1];
            end else if (state == S_SHIFT) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                res  <= {bit_d, res[WIDTH-1:1]};
                brw  <= brw_nxt;
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised and directed bench for serial_subtractor; expected results come from
// plain integer arithmetic on the operands.
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int LATENCY = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;
    logic             Busy;
    logic             Done;

    int numChecks = 0;
    int numFails  = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B), .Bin(Bin),
        .Diff(Diff), .Bout(Bout), .Ovf(Ovf), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: integer subtraction, unsigned borrow, and the MSB-based overflow rule.
    task automatic modelSub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                            output logic [WIDTH-1:0] d, output logic bo, output logic ov);
        int full;
        full = int'(a) - int'(b) - int'(bin);
        d    = WIDTH'(full);
        bo   = (full < 0);
        ov   = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    endtask

    task automatic checkResult(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        logic [WIDTH-1:0] d;
        logic bo, ov;
        modelSub(a, b, bin, d, bo, ov);
        checkOutput({tag, "_diff"}, Diff, d);
        checkOutput({tag, "_bout"}, Bout, bo);
        checkOutput({tag, "_ovf"}, Ovf, ov);
    endtask

    // Counts rising edges until Done is seen, bounded so a stuck DUT cannot hang the run.
    task automatic waitDone(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!Done && n < 4 * LATENCY);
    endtask

    task automatic countDonePulses(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (Done) pulses++;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        int n;
        @(negedge clk);
        A = a; B = b; Bin = bin; Start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, "_busy"}, Busy, 1'b1);
        @(negedge clk);
        Start = 1'b0;
        A = $urandom; B = $urandom; Bin = $urandom;
        waitDone(n);
        checkOutput({tag, "_latency"}, n, LATENCY);
        checkResult(tag, a, b, bin);
        @(posedge clk);
        #1;
        checkOutput({tag, "_pulse"}, Done, 1'b0);
    endtask

    initial begin
        int n;
        int pulses;

        rst = 1'b1; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_diff", Diff, 0);
        checkOutput("rst_flags", {Bout, Ovf, Busy, Done}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("d100_37", 8'd100, 8'd37, 1'b0);
        applyStimulus("d05_0a", 8'h05, 8'h0A, 1'b0);
        applyStimulus("d80_01", 8'h80, 8'h01, 1'b0);
        applyStimulus("d7f_ff", 8'h7F, 8'hFF, 1'b0);
        applyStimulus("d00_ff_b", 8'h00, 8'hFF, 1'b1);
        applyStimulus("d3c_3c_b", 8'h3C, 8'h3C, 1'b1);

        // A second Start three cycles into an operation must not disturb it.
        @(negedge clk);
        A = 8'd100; B = 8'd37; Bin = 1'b0; Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        repeat (2) @(negedge clk);
        A = 8'h11; B = 8'h22; Bin = 1'b1; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        waitDone(n);
        checkOutput("ign_latency", n, LATENCY - 3);
        checkResult("ign", 8'd100, 8'd37, 1'b0);
        countDonePulses(2 * LATENCY, pulses);
        checkOutput("ign_no_extra_done", pulses, 0);

        // Start held high through DONE with new operands: back-to-back acceptance.
        @(negedge clk);
        A = 8'h05; B = 8'h0A; Bin = 1'b0; Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        A = 8'h80; B = 8'h01; Bin = 1'b0;
        waitDone(n);
        checkOutput("b2b_latency1", n, LATENCY);
        checkResult("b2b1", 8'h05, 8'h0A, 1'b0);
        checkOutput("b2b_busy", Busy, 1'b1);
        @(negedge clk);
        Start = 1'b0;
        waitDone(n);
        checkOutput("b2b_latency2", n, LATENCY);
        checkResult("b2b2", 8'h80, 8'h01, 1'b0);

        // Reset during the fourth SHIFT cycle aborts without a Done pulse.
        @(negedge clk);
        A = 8'hC3; B = 8'h5A; Bin = 1'b0; Start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_diff", Diff, 0);
        checkOutput("abort_flags", {Bout, Ovf, Busy, Done}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        countDonePulses(2 * LATENCY, pulses);
        checkOutput("abort_no_done", pulses, 0);
        applyStimulus("after_abort", 8'd100, 8'd37, 1'b0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus($sformatf("rnd%0d", i), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
